stream_pattern_gen: RTL and testbench

Configurable test-pattern source that sits directly upstream of the `axis` engine's write-stream port (`wr_data`/`wr_valid`/`wr_ready`) in place of the config-register push path. It is programmed over the same flat cfg write bus (`cfg_addr`/`cfg_data`/`cfg_valid`) that `axi4lite_cfg` drives. On a start command it emits a fixed number of incrementing or LFSR words at up to one beat per cycle. Its status outputs are readable through the top-level cfg read mux.

---
 rtl/stream_pattern_pkg.sv | 21 ++
 rtl/pattern_lfsr.sv | 14 +
 rtl/stream_pattern_gen.sv | 154 +++++++++++++++
 tb/tb_stream_pattern_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pattern_pkg.sv
// Shared constants for the stream pattern generator: CTRL bit positions,
// LFSR polynomial, FSM state encoding and default cfg offsets.
package stream_pattern_pkg;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_MODE  = 1;
  localparam int unsigned CTRL_ABORT = 2;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam int unsigned CFG_SEED_DEF  = 7;
  localparam int unsigned CFG_COUNT_DEF = 8;
  localparam int unsigned CFG_CTRL_DEF  = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_lfsr.sv
// Combinational 32-bit right-shifting Galois LFSR step.
// Only compiled when STREAM_PATTERN_LFSR_EN is defined.
`ifdef STREAM_PATTERN_LFSR_EN
module pattern_lfsr
  import stream_pattern_pkg::*;
(
  input  logic [31:0] i_state,
  output logic [31:0] o_next
);

  assign o_next = i_state[0] ? ((i_state >> 1) ^ LFSR_POLY) : (i_state >> 1);

endmodule
`endif

// File: rtl/stream_pattern_gen.sv
// Test-pattern source for the write-stream port, programmed over the cfg bus.
// STREAM_PATTERN_LFSR_EN adds the LFSR mode (CTRL bit1); otherwise increment only.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; outputs idle, done/sent_cnt hold last run
// ST_RUN   | emitting beats, wr_valid high, one beat per handshake
// ST_DRAIN | abort seen during a stall; hold current beat until accepted
module stream_pattern_gen
  import stream_pattern_pkg::*;
#(
  parameter int unsigned CFG_AWIDTH   = 5,
  parameter int unsigned CFG_DWIDTH   = 32,
  parameter int unsigned STREAM_WIDTH = 32,
  parameter int unsigned CFG_SEED     = CFG_SEED_DEF,
  parameter int unsigned CFG_COUNT    = CFG_COUNT_DEF,
  parameter int unsigned CFG_CTRL     = CFG_CTRL_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CFG_AWIDTH-1:0]   cfg_addr,
  input  logic [CFG_DWIDTH-1:0]   cfg_data,
  input  logic                    cfg_valid,
  output logic [STREAM_WIDTH-1:0] wr_data,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic                    busy,
  output logic                    done,
  output logic [CFG_DWIDTH-1:0]   sent_cnt
);

  state_t                  r_state;
  logic [STREAM_WIDTH-1:0] r_seed;
  logic [STREAM_WIDTH-1:0] r_wr_data;
  logic [CFG_DWIDTH-1:0]   r_count;
  logic [CFG_DWIDTH-1:0]   r_run_count;
  logic [CFG_DWIDTH-1:0]   r_sent_cnt;
  logic                    r_wr_valid;
  logic                    r_done;

  logic                    w_seed_wr;
  logic                    w_count_wr;
  logic                    w_ctrl_wr;
  logic                    w_start;
  logic                    w_abort;
  logic                    w_hs;
  logic [CFG_DWIDTH-1:0]   w_sent_inc;
  logic [STREAM_WIDTH-1:0] w_next;
  logic [STREAM_WIDTH-1:0] w_first;

  assign w_seed_wr  = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_SEED));
  assign w_count_wr = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_COUNT));
  assign w_ctrl_wr  = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_CTRL));
  // abort wins over start when both arrive in the same CTRL word
  assign w_start    = w_ctrl_wr && cfg_data[CTRL_START] && !cfg_data[CTRL_ABORT];
  assign w_abort    = w_ctrl_wr && cfg_data[CTRL_ABORT];
  assign w_hs       = r_wr_valid && wr_ready;
  assign w_sent_inc = r_sent_cnt + CFG_DWIDTH'(1);

`ifdef STREAM_PATTERN_LFSR_EN
  logic        r_mode;
  logic [31:0] w_lfsr_next;

  if (STREAM_WIDTH != 32) begin : g_width_check
    $error("stream_pattern_gen: LFSR mode requires STREAM_WIDTH == 32");
  end

  pattern_lfsr u_lfsr (
    .i_state (r_wr_data),
    .o_next  (w_lfsr_next)
  );

  // seed 0 would lock the LFSR, so it starts from 1 instead
  assign w_first = (cfg_data[CTRL_MODE] && (r_seed == '0)) ? STREAM_WIDTH'(1) : r_seed;
  assign w_next  = r_mode ? w_lfsr_next : r_wr_data + STREAM_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
    end else if (r_state == ST_IDLE && w_start) begin
      r_mode <= cfg_data[CTRL_MODE];
    end
  end
`else
  assign w_first = r_seed;
  assign w_next  = r_wr_data + STREAM_WIDTH'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_seed      <= '0;
      r_count     <= '0;
      r_run_count <= '0;
      r_sent_cnt  <= '0;
      r_wr_data   <= '0;
      r_wr_valid  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_seed_wr)  r_seed  <= STREAM_WIDTH'(cfg_data);
      if (w_count_wr) r_count <= cfg_data;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_sent_cnt  <= '0;
            r_run_count <= r_count;
            r_done      <= (r_count == '0);
            if (r_count != '0) begin
              r_state    <= ST_RUN;
              r_wr_valid <= 1'b1;
              r_wr_data  <= w_first;
            end
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            if (wr_ready) begin
              r_sent_cnt <= w_sent_inc;
              r_wr_valid <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else if (w_hs) begin
            r_sent_cnt <= w_sent_inc;
            if (w_sent_inc == r_run_count) begin
              r_wr_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_wr_data <= w_next;
            end
          end
        end
        ST_DRAIN: begin
          if (wr_ready) begin
            r_sent_cnt <= w_sent_inc;
            r_wr_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_data  = r_wr_data;
  assign wr_valid = r_wr_valid;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign sent_cnt = r_sent_cnt;

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Self-checking bench for stream_pattern_gen; expected words come from an
// arithmetic / Galois-step model of the pattern rules.
module tb_stream_pattern_gen;

  localparam logic [4:0] A_SEED  = 5'd7;
  localparam logic [4:0] A_COUNT = 5'd8;
  localparam logic [4:0] A_CTRL  = 5'd9;

  logic        clk;
  logic        rst_n;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic [31:0] sent_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  stream_pattern_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .done      (done),
    .sent_cnt  (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat k of a run, straight from the pattern rules.
  function automatic logic [31:0] exp_word(input logic [31:0] seed, input int k, input bit lfsr);
    logic [31:0] s;
    bit use_lfsr;
    use_lfsr = lfsr;
`ifndef STREAM_PATTERN_LFSR_EN
    use_lfsr = 1'b0;
`endif
    if (!use_lfsr) return seed + 32'(k);
    s = (seed == 32'h0) ? 32'h1 : seed;
    for (int i = 0; i < k; i++)
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
  endfunction

  // Called at a negedge; returns at the negedge after the write is taken.
  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_data  = d;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({wr_valid, busy, done} !== 3'b000 || wr_data !== 32'h0 || sent_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: valid=%0b busy=%0b done=%0b data=%h cnt=%0d, required all zero",
               wr_valid, busy, done, wr_data, sent_cnt);
    end
  endtask

  // rdy_mode: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
  task automatic test_stream_run(input string name, input logic [31:0] seed,
                                 input int count, input bit lfsr, input int rdy_mode);
    int idx;
    int cyc;
    bit rdy;
    bit stalled;
    logic [31:0] held;
    logic [31:0] exp;
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    cfg_write(A_SEED, seed);
    cfg_write(A_COUNT, 32'(count));
    cfg_write(A_CTRL, lfsr ? 32'h3 : 32'h1);
    while (idx < count && cyc < count * 4 + 20) begin
      exp = exp_word(seed, idx, lfsr);
      n_checks++;
      if (wr_valid !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s valid beat %0d: valid=%0b busy=%0b, required 1/1", name, idx, wr_valid, busy);
      end
      n_checks++;
      if (wr_data !== exp) begin
        n_fail++;
        $display("FAIL %s data beat %0d: got %h, required %h", name, idx, wr_data, exp);
      end
      if (stalled) begin
        n_checks++;
        if (wr_data !== held) begin
          n_fail++;
          $display("FAIL %s stall hold beat %0d: got %h, required %h", name, idx, wr_data, held);
        end
      end
      n_checks++;
      if (sent_cnt !== 32'(idx)) begin
        n_fail++;
        $display("FAIL %s sent_cnt: got %0d, required %0d", name, sent_cnt, idx);
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      wr_ready = rdy;
      held = wr_data;
      stalled = !rdy;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    wr_ready = 1'b0;
    n_checks++;
    if (idx != count) begin
      n_fail++;
      $display("FAIL %s timeout: accepted %0d, required %0d", name, idx, count);
    end
    n_checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || sent_cnt !== 32'(count)) begin
      n_fail++;
      $display("FAIL %s completion: valid=%0b busy=%0b done=%0b cnt=%0d, required 0/0/1/%0d",
               name, wr_valid, busy, done, sent_cnt, count);
    end
  endtask

  task automatic test_zero_count();
    cfg_write(A_COUNT, 32'h0);
    cfg_write(A_CTRL, 32'h1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || sent_cnt !== 32'h0) begin
        n_fail++;
        $display("FAIL zero_count cycle %0d: valid=%0b busy=%0b done=%0b cnt=%0d, required 0/0/1/0",
                 i, wr_valid, busy, done, sent_cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    logic [31:0] seed;
    logic [31:0] held;
    int acc;
    int nrun;
    int nst;
    seed = $urandom;
    nrun = $urandom_range(2, 6);
    nst  = $urandom_range(1, 3);
    acc  = 0;
    cfg_write(A_SEED, seed);
    cfg_write(A_COUNT, 32'd100);
    cfg_write(A_CTRL, 32'h1);
    for (int i = 0; i < nrun; i++) begin
      n_checks++;
      if (wr_data !== seed + 32'(acc)) begin
        n_fail++;
        $display("FAIL abort run beat %0d: got %h, required %h", acc, wr_data, seed + 32'(acc));
      end
      wr_ready = 1'b1;
      if (i == 0) begin
        cfg_addr = A_CTRL; cfg_data = 32'h1; cfg_valid = 1'b1;
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      acc++;
    end
    wr_ready = 1'b0;
    @(negedge clk);
    held = wr_data;
    n_checks++;
    if (held !== seed + 32'(acc) || wr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort pre-stall: data=%h valid=%0b, required %h/1", held, wr_valid, seed + 32'(acc));
    end
    cfg_write(A_CTRL, 32'h4);
    for (int i = 0; i < nst; i++) begin
      n_checks++;
      if (wr_valid !== 1'b1 || busy !== 1'b1 || wr_data !== held) begin
        n_fail++;
        $display("FAIL abort drain hold: valid=%0b busy=%0b data=%h, required 1/1/%h",
                 wr_valid, busy, wr_data, held);
      end
      @(negedge clk);
    end
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    acc++;
    n_checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sent_cnt !== 32'(acc)) begin
      n_fail++;
      $display("FAIL abort drain end: valid=%0b busy=%0b done=%0b cnt=%0d, required 0/0/0/%0d",
               wr_valid, busy, done, sent_cnt, acc);
    end
    cfg_write(A_CTRL, 32'h1);
    wr_ready = 1'b1;
    @(negedge clk);
    cfg_addr = A_CTRL; cfg_data = 32'h4; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    wr_ready = 1'b0;
    n_checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sent_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL abort ready-high: valid=%0b busy=%0b done=%0b cnt=%0d, required 0/0/0/2",
               wr_valid, busy, done, sent_cnt);
    end
    cfg_write(A_CTRL, 32'h5);
    n_checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || sent_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL start_abort_same_word: valid=%0b busy=%0b cnt=%0d, required 0/0/2",
               wr_valid, busy, sent_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] seed;
    seed = $urandom;
    cfg_write(A_SEED, seed);
    cfg_write(A_COUNT, 32'd10);
    cfg_write(A_CTRL, 32'h1);
    wr_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (wr_data !== seed + 32'd5 || sent_cnt !== 32'd5 || wr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset pre: data=%h cnt=%0d valid=%0b, required %h/5/1",
               wr_data, sent_cnt, wr_valid, seed + 32'd5);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_valid, busy, done} !== 3'b000 || sent_cnt !== 32'h0 || wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%0b busy=%0b done=%0b cnt=%0d data=%h, required all zero",
               wr_valid, busy, done, sent_cnt, wr_data);
    end
    wr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    test_stream_run("post_reset", seed, 10, 1'b0, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    cfg_valid = 1'b0;
    wr_ready  = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_stream_run("incr", 32'h10, 4, 1'b0, 0);
    test_stream_run("backpressure", 32'h10, 4, 1'b0, 1);
    test_stream_run("wrap", 32'hFFFF_FFFE, 3, 1'b0, 0);
    test_zero_count();
    test_stream_run("lfsr_seed0", 32'h0, 16, 1'b1, 0);
    test_stream_run("lfsr_bp", $urandom, 12, 1'b1, 2);
    for (int r = 0; r < 4; r++)
      test_stream_run("random", $urandom, $urandom_range(1, 24), 1'($urandom_range(0, 1)), 2);
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
